pipelined_addsub: RTL and testbench



---
 rtl/alu_pkg.sv | 20 ++
 rtl/addsub_segment.sv | 33 +++
 rtl/pipelined_addsub.sv | 180 ++++++++++++++++++
 tb/tb_pipelined_addsub.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU datapath definitions: default widths, add/sub op encoding and
// the per-bit helper used to build signed saturation limits.
package alu_pkg;

  // Default datapath width and carry-select segment width.
  localparam int ALU_WIDTH     = 32;
  localparam int ADD_SEG_WIDTH = 16;

  // Add/subtract op encoding carried on the in_sub port.
  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  // One bit of a signed saturation limit. Signed max is 0 followed by ones,
  // signed min is 1 followed by zeros. So the MSB equals the "negative" flag
  // and every other bit is its complement.
  function automatic logic sat_bit(input logic neg, input logic is_msb);
    return is_msb ? neg : ~neg;
  endfunction

endpackage

// File: rtl/addsub_segment.sv
// Combinational carry-select slice. It computes the sum for carry-in 0 and
// for carry-in 1 at the same time, then lets the incoming carry pick one. It
// also reports the carry into its top bit, which the top segment uses for
// signed overflow.
module addsub_segment #(
  parameter int W = 16
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         cmsb
);

  logic [W:0] s0;
  logic [W:0] s1;
  logic       cm0;
  logic       cm1;

  // Both carry-in cases, then select with the incoming carry.
  always_comb begin
    s0   = {1'b0, a} + {1'b0, b};
    s1   = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, 1'b1};
    // The carry into bit W-1 is recovered from the sum bit and the operand bits.
    cm0  = s0[W-1] ^ a[W-1] ^ b[W-1];
    cm1  = s1[W-1] ^ a[W-1] ^ b[W-1];
    sum  = cin ? s1[W-1:0] : s0[W-1:0];
    cout = cin ? s1[W]     : s0[W];
    cmsb = cin ? cm1       : cm0;
  end

endmodule

// File: rtl/pipelined_addsub.sv
// Pipelined add/subtract. The WIDTH-bit operation is split into
// NSEG = WIDTH/SEG_WIDTH carry-select segments, one segment per stage, with
// the carry registered between stages. Latency is NSEG cycles and throughput
// is one result per cycle.
//
// Optional build macro PIPELINED_ADDSUB_SAT_EN: when it is defined, results
// that overflow saturate to signed max or min, chosen by the sign of A.
// When it is undefined, results wrap modulo 2^WIDTH.
//
// Handshake: in_valid/in_ready and out_valid/out_ready are plain valid/ready
// pairs. A transfer happens on a rising edge where both are 1. The whole
// pipeline moves on a single enable adv = !out_valid | out_ready. The input
// side is ready exactly when adv=1, so the upstream side never has to wait
// for an empty slot. A held result (out_valid & !out_ready) keeps every
// out_* register frozen.
module pipelined_addsub
  import alu_pkg::*;
#(
  parameter int WIDTH     = ALU_WIDTH,
  parameter int SEG_WIDTH = ADD_SEG_WIDTH
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic             in_sub,
  input  logic             in_cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_cout,
  output logic             out_ovf,
  output logic             out_zero
);

  localparam int NSEG = WIDTH / SEG_WIDTH;
  localparam int LAST = NSEG - 1;

  // Global advance enable shared by every stage.
  logic adv;
  assign adv      = !out_valid | out_ready;
  assign in_ready = adv;

  // Operand conditioning for stage 0. Subtraction is A + ~B + 1, and the
  // extra carry-in is ignored while subtracting.
  logic [WIDTH-1:0] b_eff;
  logic             cin0;
  assign b_eff = (in_sub == OP_SUB) ? ~in_b : in_b;
  assign cin0  = (in_sub == OP_SUB) ? 1'b1 : in_cin;

  // Stage inputs (combinational) and stage registers. Operands are kept
  // shifted so that the segment a stage works on always sits in the low
  // SEG_WIDTH bits. Finished sum segments enter the partial sum from the top,
  // so after the last stage the sum is complete and correctly aligned.
  logic             v_in    [NSEG];
  logic             c_in    [NSEG];
  logic [WIDTH-1:0] a_in    [NSEG];
  logic [WIDTH-1:0] b_in    [NSEG];
  logic [WIDTH-1:0] s_nxt   [NSEG];

  logic             v_q     [NSEG];
  logic             c_q     [NSEG];
  logic [WIDTH-1:0] a_q     [NSEG];
  logic [WIDTH-1:0] b_q     [NSEG];
  logic [WIDTH-1:0] s_q     [NSEG];

  logic [SEG_WIDTH-1:0] seg_sum  [NSEG];
  logic                 seg_cout [NSEG];
  logic                 seg_cmsb [NSEG];

  for (genvar k = 0; k < NSEG; k++) begin : g_stage
    if (k == 0) begin : g_src
      assign v_in[k] = in_valid;
      assign c_in[k] = cin0;
      assign a_in[k] = in_a;
      assign b_in[k] = b_eff;
    end else begin : g_src
      assign v_in[k] = v_q[k-1];
      assign c_in[k] = c_q[k-1];
      assign a_in[k] = a_q[k-1];
      assign b_in[k] = b_q[k-1];
    end

    addsub_segment #(
      .W (SEG_WIDTH)
    ) u_seg (
      .a    (a_in[k][SEG_WIDTH-1:0]),
      .b    (b_in[k][SEG_WIDTH-1:0]),
      .cin  (c_in[k]),
      .sum  (seg_sum[k]),
      .cout (seg_cout[k]),
      .cmsb (seg_cmsb[k])
    );

    if (NSEG == 1) begin : g_acc
      assign s_nxt[k] = seg_sum[k];
    end else if (k == 0) begin : g_acc
      assign s_nxt[k] = {seg_sum[k], {(WIDTH-SEG_WIDTH){1'b0}}};
    end else begin : g_acc
      assign s_nxt[k] = {seg_sum[k], s_q[k-1][WIDTH-1:SEG_WIDTH]};
    end
  end

  // Skew and carry registers between stages. A stage that receives no
  // accepted input loads valid=0. Its data is don't-care and is loaded anyway.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end
    end else if (adv) begin
      for (int k = 0; k < NSEG; k++) begin
        v_q[k] <= v_in[k];
        c_q[k] <= seg_cout[k];
        a_q[k] <= a_in[k] >> SEG_WIDTH;
        b_q[k] <= b_in[k] >> SEG_WIDTH;
        s_q[k] <= s_nxt[k];
      end
    end
  end

  // Final-stage result and flags, before the output register.
  logic [WIDTH-1:0] fin_sum;
  logic             fin_cout;
  logic             fin_cmsb;
  logic             fin_ovf;
  assign fin_cout = seg_cout[LAST];
  assign fin_cmsb = seg_cmsb[LAST];
  assign fin_ovf  = fin_cout ^ fin_cmsb;

`ifdef PIPELINED_ADDSUB_SAT_EN
  // The top segment of A reaches the last stage together with its low bits,
  // so the sign of A is available there directly.
  logic             a_neg;
  logic [WIDTH-1:0] sat_val;
  assign a_neg = a_in[LAST][SEG_WIDTH-1];
  for (genvar i = 0; i < WIDTH; i++) begin : g_sat
    assign sat_val[i] = sat_bit(a_neg, i == WIDTH - 1);
  end
  assign fin_sum = fin_ovf ? sat_val : s_nxt[LAST];
`else
  assign fin_sum = s_nxt[LAST];
`endif

  // Output register. It is all-zero while no result is present, and it is
  // frozen while a result is held by backpressure.
  logic cmsb_q;
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
      cmsb_q    <= 1'b0;
      out_zero  <= 1'b0;
    end else if (adv) begin
      out_valid <= v_in[LAST];
      if (v_in[LAST]) begin
        out_sum  <= fin_sum;
        out_cout <= fin_cout;
        cmsb_q   <= fin_cmsb;
        out_zero <= ~|fin_sum;
      end else begin
        out_sum  <= '0;
        out_cout <= 1'b0;
        cmsb_q   <= 1'b0;
        out_zero <= 1'b0;
      end
    end
  end

  // Signed overflow: carry into the MSB differs from the carry out of it.
  assign out_ovf = out_cout ^ cmsb_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// Directed bench for pipelined_addsub: a 32-bit/16-bit-segment instance and
// a 64-bit/16-bit-segment instance.
module tb_pipelined_addsub;

  localparam int W = 32;

`ifdef PIPELINED_ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clock;
  logic reset_n;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // ---------------- 32-bit DUT ----------------
  logic         in_valid, in_ready, in_sub, in_cin;
  logic [W-1:0] in_a, in_b, out_sum;
  logic         out_valid, out_ready, out_cout, out_ovf, out_zero;

  pipelined_addsub #(.WIDTH(32), .SEG_WIDTH(16)) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_sub    (in_sub),
    .in_cin    (in_cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_cout  (out_cout),
    .out_ovf   (out_ovf),
    .out_zero  (out_zero)
  );

  // ---------------- 64-bit DUT ----------------
  logic        in_valid_w, in_ready_w, in_sub_w, in_cin_w;
  logic [63:0] in_a_w, in_b_w, out_sum_w;
  logic        out_valid_w, out_ready_w, out_cout_w, out_ovf_w, out_zero_w;

  pipelined_addsub #(.WIDTH(64), .SEG_WIDTH(16)) dut_w (
    .clock     (clock),
    .reset_n   (reset_n),
    .in_valid  (in_valid_w),
    .in_ready  (in_ready_w),
    .in_a      (in_a_w),
    .in_b      (in_b_w),
    .in_sub    (in_sub_w),
    .in_cin    (in_cin_w),
    .out_valid (out_valid_w),
    .out_ready (out_ready_w),
    .out_sum   (out_sum_w),
    .out_cout  (out_cout_w),
    .out_ovf   (out_ovf_w),
    .out_zero  (out_zero_w)
  );

  // ---------------- vectors and scoreboard ----------------
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         zero;
  } vec_t;

  vec_t vecs[12];

  logic [W+2:0] exp_q[$];
  logic [W+2:0] mon_e;
  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every consumed result is popped and compared, and every
  // cycle without a result must show all-zero outputs.
  always @(negedge clock) begin
    if (reset_n) begin
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %h expected none", {out_cout, out_ovf, out_zero, out_sum});
        end else begin
          mon_e = exp_q.pop_front();
          check("result", 64'({out_cout, out_ovf, out_zero, out_sum}), 64'(mon_e));
        end
      end else if (!out_valid) begin
        check("idle_zero", 64'({out_cout, out_ovf, out_zero, out_sum}), 64'd0);
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input vec_t v, input bit push);
    bit ok;
    int n;
    in_a     = v.a;
    in_b     = v.b;
    in_sub   = v.sub;
    in_cin   = v.cin;
    in_valid = 1'b1;
    ok = 1'b0;
    n  = 0;
    while (!ok && n < 50) begin
      @(negedge clock);
      ok = in_ready;
      @(posedge clock);
      #1;
      n++;
    end
    in_valid = 1'b0;
    if (!ok) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout: got no accept expected accept within 50 cycles");
    end else if (push) begin
      exp_q.push_back({v.cout, v.ovf, v.zero, v.sum});
    end
  endtask

  task automatic latency_test(input vec_t v, input string name);
    int cyc;
    send(v, 1'b1);
    cyc = 1;
    while (!out_valid && cyc < 20) begin
      @(posedge clock);
      #1;
      cyc++;
    end
    check(name, 64'(cyc), 64'd2);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 50) begin
      @(posedge clock);
      #1;
      n++;
    end
    check(name, 64'(exp_q.size()), 64'd0);
  endtask

  // ---------------- test ----------------
  initial begin
    vecs[0]  = '{32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[2]  = '{32'h00000005, 32'h00000007, 1'b1, 1'b0, 32'hFFFFFFFE, 1'b0, 1'b0, 1'b0};
    vecs[3]  = '{32'h80000000, 32'h00000001, 1'b1, 1'b0, SAT ? 32'h80000000 : 32'h7FFFFFFF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{32'h0000FFFF, 32'h00000000, 1'b0, 1'b1, 32'h00010000, 1'b0, 1'b0, 1'b0};
    vecs[5]  = '{32'h0000000A, 32'h00000003, 1'b1, 1'b1, 32'h00000007, 1'b1, 1'b0, 1'b0};
    vecs[6]  = '{32'h12345678, 32'h12345678, 1'b1, 1'b0, 32'h00000000, 1'b1, 1'b0, 1'b1};
    vecs[7]  = '{32'h80000000, 32'h80000000, 1'b0, 1'b0, SAT ? 32'h80000000 : 32'h00000000, 1'b1, 1'b1, !SAT};
    vecs[8]  = '{32'h1234FFFF, 32'h00010001, 1'b0, 1'b0, 32'h12360000, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{32'h00000000, 32'h00000001, 1'b1, 1'b0, 32'hFFFFFFFF, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{32'h00000000, 32'h00000000, 1'b0, 1'b0, 32'h00000000, 1'b0, 1'b0, 1'b1};
    vecs[11] = '{32'h7FFFFFFF, 32'hFFFFFFFF, 1'b1, 1'b0, SAT ? 32'h7FFFFFFF : 32'h80000000, 1'b0, 1'b1, 1'b0};

    in_valid    = 1'b0;
    in_a        = '0;
    in_b        = '0;
    in_sub      = 1'b0;
    in_cin      = 1'b0;
    out_ready   = 1'b1;
    in_valid_w  = 1'b0;
    in_a_w      = '0;
    in_b_w      = '0;
    in_sub_w    = 1'b0;
    in_cin_w    = 1'b0;
    out_ready_w = 1'b1;
    reset_n     = 1'b1;

    // Reset state.
    #1 reset_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_outputs", 64'({out_cout, out_ovf, out_zero, out_sum}), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check("post_rst_in_ready", 64'(in_ready), 64'd1);

    // Latency with out_ready held high.
    latency_test(vecs[0], "latency");
    drain("drain_latency");

    // Table: all vectors back to back.
    for (int i = 0; i < 12; i++) send(vecs[i], 1'b1);
    drain("drain_table");

    // Backpressure: four back-to-back ops, output held for three cycles.
    fork
      begin
        for (int i = 0; i < 4; i++) send(vecs[i + 1], 1'b1);
      end
      begin
        int n;
        logic [W-1:0] held;
        n = 0;
        while (!out_valid && n < 20) begin
          @(posedge clock);
          #1;
          n++;
        end
        out_ready = 1'b0;
        held = out_sum;
        repeat (3) begin
          @(posedge clock);
          #1;
          check("bp_in_ready", 64'(in_ready), 64'd0);
          check("bp_valid_held", 64'(out_valid), 64'd1);
          check("bp_sum_stable", 64'(out_sum), 64'(held));
        end
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
          check("bp_no_gap", 64'(out_valid), 64'd1);
          @(posedge clock);
          #1;
        end
      end
    join
    drain("drain_bp");

    // Reset in the middle of two in-flight ops.
    out_ready = 1'b0;
    send(vecs[4], 1'b0);
    send(vecs[5], 1'b0);
    reset_n = 1'b0;
    #1;
    check("midrst_valid", 64'(out_valid), 64'd0);
    check("midrst_outputs", 64'({out_cout, out_ovf, out_zero, out_sum}), 64'd0);
    @(posedge clock);
    #1 reset_n = 1'b1;
    out_ready = 1'b1;
    repeat (3) begin
      @(posedge clock);
      #1;
      check("after_rst_valid", 64'(out_valid), 64'd0);
      check("after_rst_sum", 64'(out_sum), 64'd0);
    end
    latency_test(vecs[1], "after_rst_latency");
    drain("drain_rst");

    // 64-bit instance: four segments, four cycles.
    begin
      bit rdy;
      int cyc;
      in_a_w     = 64'h0000FFFFFFFFFFFF;
      in_b_w     = 64'h0000000000000001;
      in_valid_w = 1'b1;
      @(negedge clock);
      rdy = in_ready_w;
      @(posedge clock);
      #1;
      in_valid_w = 1'b0;
      check("w_accept", 64'(rdy), 64'd1);
      cyc = 1;
      while (!out_valid_w && cyc < 20) begin
        @(posedge clock);
        #1;
        cyc++;
      end
      check("w_latency", 64'(cyc), 64'd4);
      check("w_sum", out_sum_w, 64'h0001000000000000);
      check("w_flags", 64'({out_cout_w, out_ovf_w, out_zero_w}), 64'd0);
    end

    repeat (2) @(posedge clock);
    #1;
    check("final_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
